// File: rtl/src_ctrl.sv
// Input-side stream controller: captures one valid/ready/last frame into the local buffer
// and raises stream_ok once the final write commits. Optional length check: SRC_CTRL_LEN_CHK_EN.
module src_ctrl #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          src_valid,
  input  logic          src_last,
  input  logic [DW-1:0] src_data,
  output logic          src_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          stream_ok,
  output logic [AW:0]   beat_cnt,
  output logic          err_len,
  output logic [1:0]    dbg_state
);

  // Handshake: a beat transfers on a rising clk edge when src_valid & src_ready are both
  // high; src_ready depends only on state and run, never on src_valid.
  typedef enum logic [1:0] {IDLE, RECV, FLUSH, DONE} state_t;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] d_q, d_d;
  logic          accept;

  assign src_ready = run && (state_q == RECV);
  assign accept    = src_valid && src_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    a_d     = a_q;
    d_d     = d_q;
    if (!run) begin
      // run low wins over everything, including a write about to be issued
      state_d = IDLE;
      cnt_d   = '0;
      a_d     = '0;
      d_d     = '0;
    end else begin
      case (state_q)
        IDLE: state_d = RECV;
        RECV: begin
          if (accept) begin
            we_d  = 1'b1;
            a_d   = cnt_q[AW-1:0];
            d_d   = src_data;
            cnt_d = cnt_q + 1'b1;
            if (src_last || (cnt_q == LAST_IDX)) state_d = FLUSH;
          end
        end
        FLUSH:   state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      a_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      a_q     <= a_d;
      d_q     <= d_d;
    end
  end

`ifdef SRC_CTRL_LEN_CHK_EN
  logic last_q, last_d;
  logic err_q, err_d;

  always_comb begin
    last_d = last_q;
    err_d  = err_q;
    if (!run) begin
      last_d = 1'b0;
      err_d  = 1'b0;
    end else if (state_q == RECV && accept) begin
      last_d = src_last;
    end else if (state_q == FLUSH) begin
      // a good frame is exactly DEPTH beats terminated by src_last
      err_d = err_q | !(last_q && (cnt_q == (AW+1)'(DEPTH)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  assign err_len = err_q;
`else
  assign err_len = 1'b0;
`endif

  assign mem_we    = we_q;
  assign mem_a     = a_q;
  assign mem_d     = d_q;
  assign beat_cnt  = cnt_q;
  assign stream_ok = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_src_ctrl.sv
// Self-checking bench for src_ctrl: frame-level model plus per-cycle compare.
module tb_src_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          src_valid;
  logic          src_last;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic          stream_ok;
  logic [AW:0]   beat_cnt;
  logic          err_len;
  logic [1:0]    dbg_state;

  src_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .run(run),
    .src_valid(src_valid), .src_last(src_last), .src_data(src_data),
    .src_ready(src_ready), .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d),
    .stream_ok(stream_ok), .beat_cnt(beat_cnt), .err_len(err_len),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [AW+DW-1:0] exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   writes_seen = 0;

  // driver-side frame model
  logic acc_now = 1'b0;     // beat offered this cycle must be taken
  logic end_now = 1'b0;     // that beat closes the frame
  int   taken;
  bit   ended;
  bit   frame_err;

  // cycle-level expectation derived from accepted beats
  logic        armed, exp_we;
  logic [1:0]  stage;       // 0 receiving, 1 final write committing, 2 done
  logic [AW:0] exp_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst || !run) begin
      armed   <= 1'b0;
      exp_we  <= 1'b0;
      stage   <= 2'd0;
      exp_cnt <= '0;
    end else begin
      armed  <= 1'b1;
      exp_we <= acc_now;
      if (acc_now) exp_cnt <= exp_cnt + 1'b1;
      if (acc_now && end_now) stage <= 2'd1;
      else if (stage == 2'd1) stage <= 2'd2;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_err_f();
`ifdef SRC_CTRL_LEN_CHK_EN
    return (stage == 2'd2) && frame_err;
`else
    return 1'b0;
`endif
  endfunction

  // per-cycle compare, away from the active edge
  initial begin
    logic [AW+DW-1:0] item;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        chk("src_ready", 64'(src_ready), 64'(run && armed && stage == 2'd0));
        chk("mem_we", 64'(mem_we), 64'(exp_we));
        if (mem_we) begin
          writes_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual a=%0d d=%0h expected none", mem_a, mem_d);
          end else begin
            item = exp_q.pop_front();
            chk("write_addr_data", 64'({mem_a, mem_d}), 64'(item));
          end
        end
        chk("stream_ok", 64'(stream_ok), 64'(stage == 2'd2));
        chk("beat_cnt", 64'(beat_cnt), 64'(exp_cnt));
        chk("err_len", 64'(err_len), 64'(exp_err_f()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      src_valid = 1'b0;
      src_last  = 1'b0;
      acc_now   = 1'b0;
      end_now   = 1'b0;
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    run = 1'b1;
    taken = 0;
    ended = 0;
    frame_err = 0;
    writes_seen = 0;
  endtask

  task automatic stop_run();
    @(negedge clk);
    run = 1'b0;
    src_valid = 1'b0;
    src_last = 1'b0;
    acc_now = 1'b0;
    end_now = 1'b0;
  endtask

  // n beats, data=base+i; src_last on index last_idx (-1: never); optional gap before odd beats
  task automatic beats(input int n, input int last_idx, input bit gaps, input logic [DW-1:0] base);
    logic [AW-1:0] tk;
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 2 == 1)) idle(1);
      @(negedge clk);
      src_valid = 1'b1;
      src_last  = (i == last_idx);
      src_data  = base + DW'(i);
      acc_now   = !ended;
      end_now   = 1'b0;
      if (!ended) begin
        tk = taken[AW-1:0];
        exp_q.push_back({tk, src_data});
        if (src_last || taken == DEPTH - 1) begin
          end_now   = 1'b1;
          ended     = 1;
          frame_err = !(src_last && taken == DEPTH - 1);
        end
        taken++;
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    run = 1'b0;
    src_valid = 1'b0;
    src_last = 1'b0;
    src_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(src_ready), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_cnt", 64'(beat_cnt), 64'd0);
    chk("rst_ok", 64'(stream_ok), 64'd0);
    rst = 1'b0;
    idle(2);

    // 1: full 32-beat frame, last on beat 31
    start_frame();
    beats(32, 31, 1'b0, 32'd0);
    idle(4);
    chk("t1_writes", 64'(writes_seen), 64'd32);
    chk("t1_cnt", 64'(beat_cnt), 64'd32);
    chk("t1_ok", 64'(stream_ok), 64'd1);
    chk("t1_last_a", 64'(mem_a), 64'd31);
    chk("t1_last_d", 64'(mem_d), 64'd31);
    chk("t1_err", 64'(err_len), 64'd0);
    stop_run();
    idle(2);

    // 2: same frame with gaps
    start_frame();
    beats(32, 31, 1'b1, 32'hA000_0000);
    idle(4);
    chk("t2_writes", 64'(writes_seen), 64'd32);
    chk("t2_cnt", 64'(beat_cnt), 64'd32);
    chk("t2_last_d", 64'(mem_d), 64'hA000_001F);
    stop_run();
    idle(2);

    // 3: short frame, last on beat 7
    start_frame();
    beats(8, 7, 1'b0, 32'h0000_0500);
    idle(4);
    chk("t3_writes", 64'(writes_seen), 64'd8);
    chk("t3_cnt", 64'(beat_cnt), 64'd8);
    chk("t3_ok", 64'(stream_ok), 64'd1);
    chk("t3_last_a", 64'(mem_a), 64'd7);
`ifdef SRC_CTRL_LEN_CHK_EN
    chk("t3_err", 64'(err_len), 64'd1);
`else
    chk("t3_err", 64'(err_len), 64'd0);
`endif
    stop_run();
    idle(2);

    // 4: 40 beats, no last -> truncation at 32
    start_frame();
    beats(40, -1, 1'b0, 32'h0001_0000);
    idle(4);
    chk("t4_writes", 64'(writes_seen), 64'd32);
    chk("t4_cnt", 64'(beat_cnt), 64'd32);
    chk("t4_last_a", 64'(mem_a), 64'd31);
    chk("t4_last_d", 64'(mem_d), 64'h0001_001F);
    chk("t4_ready", 64'(src_ready), 64'd0);
`ifdef SRC_CTRL_LEN_CHK_EN
    chk("t4_err", 64'(err_len), 64'd1);
`else
    chk("t4_err", 64'(err_len), 64'd0);
`endif
    stop_run();
    idle(2);

    // 5: run dropped the cycle after beat 10 is accepted, then a fresh frame
    start_frame();
    beats(11, -1, 1'b0, 32'h0000_0C00);
    stop_run();
    @(negedge clk);
    #2;
    chk("t5_we", 64'(mem_we), 64'd0);
    chk("t5_ok", 64'(stream_ok), 64'd0);
    chk("t5_cnt", 64'(beat_cnt), 64'd0);
    chk("t5_a", 64'(mem_a), 64'd0);
    chk("t5_writes", 64'(writes_seen), 64'd11);
    start_frame();
    beats(3, 2, 1'b0, 32'h0000_0D00);
    idle(4);
    chk("t5_rearm_cnt", 64'(beat_cnt), 64'd3);
    chk("t5_rearm_a", 64'(mem_a), 64'd2);
    chk("t5_rearm_ok", 64'(stream_ok), 64'd1);
    stop_run();
    idle(2);

    // 6: asynchronous reset mid-frame
    start_frame();
    beats(5, -1, 1'b0, 32'h0000_0E00);
    idle(1);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_ready", 64'(src_ready), 64'd0);
    chk("t6_we", 64'(mem_we), 64'd0);
    chk("t6_a", 64'(mem_a), 64'd0);
    chk("t6_d", 64'(mem_d), 64'd0);
    chk("t6_cnt", 64'(beat_cnt), 64'd0);
    chk("t6_ok", 64'(stream_ok), 64'd0);
    chk("t6_err", 64'(err_len), 64'd0);
    run = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(2);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
